// File: rtl/vault_run_monitor_if.sv
// Signal bundle between the vault puzzle top (master) and its run monitor (slave).
// Strobes are single-cycle pulses with no back-pressure; each is consumed on the rising edge where it is seen.
interface vault_run_monitor_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic [4:0]       phase_done;
   logic             phase_fail;
   logic             vault_escape;
   logic             all_done;
   logic             alarm_ack;
   logic [2:0]       current_phase;
   logic [CNT_W-1:0] elapsed;
   logic [3:0]       fail_count;
   logic             escaped;
   logic [CNT_W-1:0] escape_time;
   logic             alarm;
   logic [1:0]       alarm_cause;
   logic             locked;
   // Debug view of the monitor state: 0 idle, 1 run, 2 escaped, 3 alarm, 4 lockout.
   logic [2:0]       state_dbg;

   modport master (
      output start, phase_done, phase_fail, vault_escape, all_done, alarm_ack,
      input  current_phase, elapsed, fail_count, escaped, escape_time,
             alarm, alarm_cause, locked, state_dbg
   );

   modport slave (
      input  start, phase_done, phase_fail, vault_escape, all_done, alarm_ack,
      output current_phase, elapsed, fail_count, escaped, escape_time,
             alarm, alarm_cause, locked, state_dbg
   );
endinterface

// File: rtl/vault_run_monitor.sv
// Run supervisor for the five-phase vault puzzle: times each run, tracks phase order
// and failures, and raises alarm, lockout or escape outcomes with registered outputs.
module vault_run_monitor #(
   parameter int TIME_LIMIT     = 1000,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 200,
   parameter int CNT_W          = 16
) (
   input logic               clk,
   input logic               rst,
   vault_run_monitor_if.slave mon
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_ESCAPED = 3'd2,
      S_ALARM   = 3'd3,
      S_LOCKOUT = 3'd4
   } state_t;

   localparam int               LK_W        = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] ELAPSED_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TIMEOUT_AT  = CNT_W'(TIME_LIMIT - 1);
   localparam logic [3:0]       FAIL_LIMIT  = 4'(MAX_FAILS);
   localparam logic [LK_W-1:0]  LK_LOAD     = LK_W'(LOCKOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [2:0]       phase_q, phase_d;
   logic [CNT_W-1:0] elapsed_q, elapsed_d;
   logic [CNT_W-1:0] esc_time_q, esc_time_d;
   logic [3:0]       fail_q, fail_d;
   logic [1:0]       cause_q, cause_d;
   logic             escaped_q, escaped_d;
   logic             alarm_q, alarm_d;
   logic             locked_q, locked_d;
   logic [LK_W-1:0]  lk_cnt_q, lk_cnt_d;

   logic [4:0] expect_done;
   logic       phase_ok;
   logic       seq_err;
   logic       tamper;
   logic       valid_esc;
   logic [2:0] phase_upd;
   logic [3:0] fail_upd;

   // Event decode against the phase expected next; phase 5 accepts no further strobes.
   always_comb begin
      expect_done = 5'b00001 << phase_q;
      phase_ok    = (phase_q < 3'd5) && (mon.phase_done == expect_done);
      seq_err     = (phase_q < 3'd5) && (mon.phase_done != 5'd0) && !phase_ok;
      tamper      = mon.vault_escape && (phase_q < 3'd5);
      valid_esc   = mon.vault_escape && mon.all_done && (phase_q == 3'd5);
      phase_upd   = phase_ok ? phase_q + 3'd1 : phase_q;
      fail_upd    = (mon.phase_fail && (fail_q != 4'hF)) ? fail_q + 4'd1 : fail_q;
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      elapsed_d  = elapsed_q;
      fail_d     = fail_q;
      cause_d    = cause_q;
      esc_time_d = esc_time_q;
      lk_cnt_d   = lk_cnt_q;

      unique case (state_q)
         S_IDLE, S_ESCAPED: begin
            if (mon.start) begin
               state_d   = S_RUN;
               phase_d   = 3'd0;
               elapsed_d = '0;
               fail_d    = 4'd0;
               cause_d   = 2'b00;
            end
         end
         S_RUN: begin
            phase_d = phase_upd;
            fail_d  = fail_upd;
            if (valid_esc) begin
               state_d    = S_ESCAPED;
               esc_time_d = elapsed_q;
            end else if (tamper) begin
               state_d = S_ALARM;
               cause_d = 2'b10;
            end else if (seq_err) begin
               state_d = S_ALARM;
               cause_d = 2'b11;
            end else if (fail_upd == FAIL_LIMIT) begin
               state_d  = S_LOCKOUT;
               lk_cnt_d = LK_LOAD;
            end else if (elapsed_q == TIMEOUT_AT) begin
               state_d = S_ALARM;
               cause_d = 2'b01;
            end else if (elapsed_q != ELAPSED_MAX) begin
               // Exit edges leave elapsed frozen at the last in-run count.
               elapsed_d = elapsed_q + CNT_W'(1);
            end
         end
         S_ALARM: begin
            if (mon.alarm_ack) begin
               state_d = S_IDLE;
               cause_d = 2'b00;
            end
         end
         S_LOCKOUT: begin
            if (lk_cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               lk_cnt_d = lk_cnt_q - LK_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      escaped_d = (state_d == S_ESCAPED);
      alarm_d   = (state_d == S_ALARM);
      locked_d  = (state_d == S_LOCKOUT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         phase_q    <= 3'd0;
         elapsed_q  <= '0;
         fail_q     <= 4'd0;
         cause_q    <= 2'b00;
         esc_time_q <= '0;
         lk_cnt_q   <= '0;
         escaped_q  <= 1'b0;
         alarm_q    <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         elapsed_q  <= elapsed_d;
         fail_q     <= fail_d;
         cause_q    <= cause_d;
         esc_time_q <= esc_time_d;
         lk_cnt_q   <= lk_cnt_d;
         escaped_q  <= escaped_d;
         alarm_q    <= alarm_d;
         locked_q   <= locked_d;
      end
   end

   assign mon.current_phase = phase_q;
   assign mon.elapsed       = elapsed_q;
   assign mon.fail_count    = fail_q;
   assign mon.escaped       = escaped_q;
   assign mon.escape_time   = esc_time_q;
   assign mon.alarm         = alarm_q;
   assign mon.alarm_cause   = cause_q;
   assign mon.locked        = locked_q;
   assign mon.state_dbg     = state_q;

endmodule

// File: tb/tb_vault_run_monitor.sv
// Bench for vault_run_monitor: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the run rules.
module tb_vault_run_monitor;

   localparam int TIME_LIMIT     = 50;
   localparam int MAX_FAILS      = 3;
   localparam int LOCKOUT_CYCLES = 10;
   localparam int CNT_W          = 16;

   // Model modes use the documented state_dbg numbering.
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_ESC   = 2;
   localparam int M_ALARM = 3;
   localparam int M_LOCK  = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   vault_run_monitor_if #(.CNT_W(CNT_W)) bus ();

   vault_run_monitor #(
      .TIME_LIMIT    (TIME_LIMIT),
      .MAX_FAILS     (MAX_FAILS),
      .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mon(bus.slave)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   int          m_mode, m_phase, m_fails, m_cause, m_lock_left;
   int unsigned m_elapsed, m_esc_time;
   logic [CNT_W-1:0] exp_q[$];
   logic        prev_esc;

   logic [4:0] pd;
   int         cnt;
   int         n_escapes;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_phase = 0; m_fails = 0; m_cause = 0; m_lock_left = 0;
      m_elapsed = 0; m_esc_time = 0;
      exp_q.delete();
      prev_esc = 1'b0;
   endtask

   task automatic model_step(input bit st, input bit [4:0] pdone, input bit pf,
                             input bit ve, input bit ad, input bit ack);
      int  ph_next;
      int  f_next;
      bit  correct;
      case (m_mode)
         M_IDLE, M_ESC: begin
            if (st) begin
               m_mode = M_RUN; m_elapsed = 0; m_phase = 0; m_fails = 0; m_cause = 0;
            end
         end
         M_RUN: begin
            correct = (m_phase < 5) && (int'(pdone) == (1 << m_phase));
            ph_next = correct ? m_phase + 1 : m_phase;
            f_next  = (m_fails + int'(pf) > 15) ? 15 : m_fails + int'(pf);
            if (ve && ad && m_phase == 5) begin
               m_mode = M_ESC; m_esc_time = m_elapsed;
               exp_q.push_back(CNT_W'(m_elapsed));
            end else if (ve && m_phase < 5) begin
               m_mode = M_ALARM; m_cause = 2;
            end else if (pdone != 0 && !correct && m_phase < 5) begin
               m_mode = M_ALARM; m_cause = 3;
            end else if (f_next == MAX_FAILS) begin
               m_mode = M_LOCK; m_lock_left = LOCKOUT_CYCLES;
            end else if (m_elapsed == TIME_LIMIT - 1) begin
               m_mode = M_ALARM; m_cause = 1;
            end else if (m_elapsed < 65535) begin
               m_elapsed++;
            end
            m_phase = ph_next;
            m_fails = f_next;
         end
         M_ALARM: begin
            if (ack) begin
               m_mode = M_IDLE; m_cause = 0;
            end
         end
         M_LOCK: begin
            m_lock_left--;
            if (m_lock_left == 0) m_mode = M_IDLE;
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   task automatic compare_all();
      check("state",       bus.state_dbg,     m_mode);
      check("phase",       bus.current_phase, m_phase);
      check("elapsed",     bus.elapsed,       m_elapsed);
      check("fail_count",  bus.fail_count,    m_fails);
      check("escaped",     bus.escaped,       m_mode == M_ESC);
      check("escape_time", bus.escape_time,   m_esc_time);
      check("alarm",       bus.alarm,         m_mode == M_ALARM);
      check("alarm_cause", bus.alarm_cause,   m_cause);
      check("locked",      bus.locked,        m_mode == M_LOCK);
      if (bus.escaped && !prev_esc) begin
         check("esc_event_pending", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) check("esc_time_sb", bus.escape_time, exp_q.pop_front());
      end
      prev_esc = bus.escaped;
   endtask

   // One clock: apply inputs, step the model at the edge, compare shortly after.
   task automatic drive(input bit st, input bit [4:0] pdone, input bit pf,
                        input bit ve, input bit ad, input bit ack);
      bus.start = st; bus.phase_done = pdone; bus.phase_fail = pf;
      bus.vault_escape = ve; bus.all_done = ad; bus.alarm_ack = ack;
      @(posedge clk);
      model_step(st, pdone, pf, ve, ad, ack);
      #1;
      bus.start = 1'b0; bus.phase_done = 5'd0; bus.phase_fail = 1'b0;
      bus.vault_escape = 1'b0; bus.all_done = 1'b0; bus.alarm_ack = 1'b0;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 5'd0, 0, 0, 0, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_state"},   bus.state_dbg,     0);
      check({tag, "_phase"},   bus.current_phase, 0);
      check({tag, "_elapsed"}, bus.elapsed,       0);
      check({tag, "_fails"},   bus.fail_count,    0);
      check({tag, "_escaped"}, bus.escaped,       0);
      check({tag, "_esctime"}, bus.escape_time,   0);
      check({tag, "_alarm"},   bus.alarm,         0);
      check({tag, "_cause"},   bus.alarm_cause,   0);
      check({tag, "_locked"},  bus.locked,        0);
   endtask

   initial begin
      bus.start = 1'b0; bus.phase_done = 5'd0; bus.phase_fail = 1'b0;
      bus.vault_escape = 1'b0; bus.all_done = 1'b0; bus.alarm_ack = 1'b0;
      model_reset();
      n_escapes = 0;

      // Power-on reset, checked before the first clock edge.
      #1 rst = 1'b1;
      #2 check_all_zero("por");
      #9 rst = 1'b0;
      @(posedge clk); #1;

      // Happy path: phases on cycles 3,6,9,12,15, escape on cycle 20.
      drive(1, 5'd0, 0, 0, 0, 0);
      for (int k = 0; k <= 20; k++) begin
         pd = (k % 3 == 0 && k >= 3 && k <= 15) ? 5'(1 << (k / 3 - 1)) : 5'd0;
         drive(0, pd, 0, k == 20, k == 20, 0);
      end
      check("happy_phase",    bus.current_phase, 5);
      check("happy_escaped",  bus.escaped,       1);
      check("happy_esc_time", bus.escape_time,   20);
      check("happy_alarm",    bus.alarm,         0);
      idle(3);

      // Timeout: start from ESCAPED, then no activity.
      drive(1, 5'd0, 0, 0, 0, 0);
      check("restart_escaped", bus.escaped, 0);
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         drive(0, 5'd0, 0, 0, 0, 0);
         cnt++;
         if (bus.alarm) break;
      end
      check("timeout_run_cycles", cnt, 50);
      check("timeout_cause",      bus.alarm_cause, 1);
      check("timeout_elapsed",    bus.elapsed, 49);
      drive(1, 5'd0, 0, 0, 0, 0);
      check("alarm_ignores_start", bus.alarm, 1);
      drive(0, 5'd0, 0, 0, 0, 1);
      check("ack_clears_alarm", bus.alarm, 0);
      check("ack_clears_cause", bus.alarm_cause, 0);

      // Lockout: fails on cycles 2,4,6; start and ack during lockout ignored.
      drive(1, 5'd0, 0, 0, 0, 0);
      for (int k = 0; k <= 6; k++) drive(0, 5'd0, (k == 2 || k == 4 || k == 6), 0, 0, 0);
      check("lock_fails",   bus.fail_count, 3);
      check("lock_entered", bus.locked, 1);
      cnt = 1;
      for (int i = 0; i < 30; i++) begin
         drive(i == 2, 5'd0, 0, 0, 0, i == 4);
         if (!bus.locked) break;
         cnt++;
      end
      check("lockout_len",       cnt, LOCKOUT_CYCLES);
      check("lockout_exit_idle", bus.state_dbg, M_IDLE);

      // Sequence error: phase 2 strobe while expecting phase 0.
      drive(1, 5'd0, 0, 0, 0, 0);
      drive(0, 5'b00100, 0, 0, 0, 0);
      check("seq_alarm", bus.alarm, 1);
      check("seq_cause", bus.alarm_cause, 3);
      drive(0, 5'd0, 0, 0, 0, 1);

      // Tamper: escape flag at phase 2.
      drive(1, 5'd0, 0, 0, 0, 0);
      drive(0, 5'b00001, 0, 0, 0, 0);
      drive(0, 5'b00010, 0, 0, 0, 0);
      drive(0, 5'd0, 0, 1, 0, 0);
      check("tamper_cause", bus.alarm_cause, 2);
      drive(0, 5'd0, 0, 0, 0, 1);

      // Correct phase strobe together with the third failure.
      drive(1, 5'd0, 0, 0, 0, 0);
      drive(0, 5'd0, 1, 0, 0, 0);
      drive(0, 5'd0, 1, 0, 0, 0);
      drive(0, 5'b00001, 1, 0, 0, 0);
      check("sim_lock_phase",  bus.current_phase, 1);
      check("sim_lock_locked", bus.locked, 1);
      idle(LOCKOUT_CYCLES);

      // Valid escape together with the third failure: escape wins.
      drive(1, 5'd0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) drive(0, 5'(1 << k), 0, 0, 0, 0);
      drive(0, 5'd0, 1, 0, 0, 0);
      drive(0, 5'd0, 1, 0, 0, 0);
      drive(0, 5'd0, 1, 1, 1, 0);
      check("sim_esc_escaped",  bus.escaped, 1);
      check("sim_esc_locked",   bus.locked, 0);
      check("sim_esc_fails",    bus.fail_count, 3);
      check("sim_esc_time",     bus.escape_time, 7);

      // Asynchronous reset mid-run at elapsed 17.
      drive(1, 5'd0, 0, 0, 0, 0);
      idle(17);
      check("pre_reset_elapsed", bus.elapsed, 17);
      #2 rst = 1'b1;
      #1 check_all_zero("midrun_rst");
      model_reset();
      #2 rst = 1'b0;
      @(posedge clk); #1;

      // Randomized traffic, biased toward legal progress.
      for (int i = 0; i < 1500; i++) begin
         int  r;
         bit  st, pf, ve, ad, ack;
         r  = $urandom_range(0, 29);
         if (r < 8 && m_phase < 5) pd = 5'(1 << m_phase);
         else if (r == 8)          pd = 5'($urandom_range(1, 31));
         else                      pd = 5'd0;
         st  = ($urandom_range(0, 5) == 0);
         pf  = ($urandom_range(0, 11) == 0);
         ve  = (m_phase == 5) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
         ad  = ve ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
         ack = ($urandom_range(0, 4) == 0);
         drive(st, pd, pf, ve, ad, ack);
         if (bus.escaped && m_mode == M_ESC) n_escapes++;
      end

      check("esc_queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vault_run_monitor.md
Name: vault_run_monitor

Overview:
- Downstream supervisor for the five-phase vault puzzle (keypad, direction, color, pattern, final key).
- Consumes the per-phase done strobes, wrong-entry strobes, and the top-level vault_escape/all_done outputs.
- Times each run, enforces a time limit and a failure limit with lockout, flags out-of-order or tamper events, and latches the escape time for display/score logic.

Parameters:
- TIME_LIMIT, 1000, run length in cycles before timeout alarm.
- MAX_FAILS, 3, failure count that triggers lockout (range 1..15).
- LOCKOUT_CYCLES, 200, lockout duration in cycles (must be at least 1).
- CNT_W, 16, width of the elapsed and escape-time counters.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run.
- phase_done  in  5  per-phase done strobes, bit0 = keypad … bit4 = final key.
- phase_fail  in  1  wrong-entry strobe from any phase FSM.
- vault_escape  in  1  escape flag from the puzzle top.
- all_done  in  1  all-phases-done flag from the puzzle top.
- alarm_ack  in  1  clears the ALARM state.
- current_phase  out  3  next expected phase, 0..5.
- elapsed  out  CNT_W  cycles since start, saturating.
- fail_count  out  4  failures in the current run.
- escaped  out  1  high while in ESCAPED.
- escape_time  out  CNT_W  elapsed value latched at escape.
- alarm  out  1  high while in ALARM.
- alarm_cause  out  2  00 = none, 01 = timeout, 10 = tamper, 11 = sequence error.
- locked  out  1  high while in LOCKOUT.

Behaviour:
- All outputs are registered. An input sampled on edge N is reflected in the outputs after edge N.
- Reset (asynchronous): state = IDLE; every output = 0; the lockout counter = 0.
- States: IDLE, RUN, ESCAPED, ALARM, LOCKOUT.
- IDLE:
  - On start: go to RUN; set elapsed = 0, current_phase = 0, fail_count = 0, alarm_cause = 00.
  - Keep escape_time until the next escape.
- RUN, each cycle, evaluated in this priority order:
  1. Valid escape: vault_escape && all_done && current_phase == 5 → ESCAPED. escape_time <= elapsed (the value before this cycle's increment).
  2. Tamper: vault_escape && current_phase < 5 → ALARM, cause 10.
  3. Sequence error: phase_done nonzero, not equal to (1 << current_phase), and current_phase < 5 → ALARM, cause 11.
  4. Lockout: the fail_count value after this cycle's update equals MAX_FAILS → LOCKOUT. The lockout counter loads LOCKOUT_CYCLES − 1.
  5. Timeout: elapsed == TIME_LIMIT − 1 → ALARM, cause 01.
  6. Otherwise stay in RUN.
- RUN side effects:
  - elapsed increments every cycle in RUN and saturates at 2^CNT_W − 1.
  - phase_done equal to (1 << current_phase) increments current_phase. It saturates at 5; phase_done after phase 5 is ignored.
  - phase_fail increments fail_count, saturating at 15.
  - A correct phase_done and phase_fail in the same cycle both take effect.
  - start is ignored while in RUN.
- ESCAPED:
  - escaped = 1.
  - elapsed, current_phase and fail_count hold.
  - start → RUN with the initialisation defined for IDLE. escaped drops the same cycle.
- ALARM:
  - alarm = 1 and alarm_cause holds; elapsed holds.
  - alarm_ack → IDLE; alarm = 0 and alarm_cause = 00 on exit.
  - start is ignored.
- LOCKOUT:
  - locked = 1.
  - The counter decrements each cycle; when it reaches 0, go to IDLE.
  - locked is therefore high for exactly LOCKOUT_CYCLES cycles.
  - start and alarm_ack are ignored.
- Reset asserted mid-run or in any state returns immediately to the reset values. escape_time also clears.
- The monitor does not count inputs received outside RUN; phase_done, phase_fail and vault_escape are don't-care there.

Test Plan:
- Bench parameters: TIME_LIMIT = 50, MAX_FAILS = 3, LOCKOUT_CYCLES = 10.
- Happy path: start; phase_done = 00001, 00010, 00100, 01000, 10000 on cycles 3, 6, 9, 12, 15; vault_escape = all_done = 1 on cycle 20 → current_phase = 5, escaped = 1, escape_time = 20, alarm = 0.
- Timeout: start, then no phase_done → alarm = 1 and alarm_cause = 01 after 50 cycles in RUN, with elapsed = 49 held; alarm_ack → IDLE and alarm = 0.
- Lockout: start; phase_fail pulses on cycles 2, 4, 6 → fail_count = 3, locked = 1 for exactly 10 cycles, then IDLE; a start during lockout is ignored.
- Sequence/tamper:
  - phase_done = 00100 while current_phase = 0 → ALARM, cause 11.
  - In a new run, vault_escape = 1 at current_phase = 2 → ALARM, cause 10.
- Simultaneity: correct phase_done together with the third phase_fail → current_phase increments and LOCKOUT is entered. vault_escape valid in the same cycle as the third phase_fail → ESCAPED wins.
- Reset mid-run at elapsed = 17 → all outputs 0 and state IDLE, asynchronously (checked before the next clock edge).
